uart_rec_char: RTL and testbench
================================

# uart_rec_char

UART monitor receive-side command decoder: pops ASCII characters from the UART RX FIFO, parses one command line (command letter plus up to two hex arguments, terminated by CR), and presents a decoded command to the monitor control. It is the inverse of the monitor's hex-encode/send path: lowercase/uppercase hex in, binary words out. Optional local echo feeds the UART TX path.

## Interface
- MAX_DIGITS, 8, maximum hex digits per argument; argument width is 4*MAX_DIGITS (32).
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- rx_char  input  8  head of RX FIFO (show-ahead), valid when rx_fifo_empty=0.
- rx_fifo_empty  input  1  RX FIFO empty.
- rx_rd  output  1  pop RX FIFO; character consumed in this cycle.
- cmd_busy  input  1  control still executing the previous command; parser stalls.
- cmd_valid  output  1  one-cycle pulse, decoded command available.
- cmd_err  output  1  one-cycle pulse, malformed line discarded.
- cmd_code  output  3  1=r (read addr1..addr2), 2=w (write addr1,data2), 3=g (go pc1), 4=q (quit); 0 idle.
- cmd_arg1  output  32  first argument, zero-extended.
- cmd_arg2  output  32  second argument, zero-extended.
- tx_fifo_full  input  1  TX FIFO full (echo back-pressure).
- echo_char  output  8  character to echo.
- echo_en  output  1  write echo_char to TX FIFO.
- crlf_out  output  1  one-cycle request to the sender to emit CR LF.

## Operation
- rx_rd = ~rx_fifo_empty & ~cmd_busy & (state != DONE) [& ~tx_fifo_full when echo compiled in].
- Required argument count: r=2, w=2, g=1, q=0. Letters accepted in either case; hex digits 0-9, a-f, A-F.
- LF (0x0a) ignored in every state.
- States:
  - IDLE: space/CR ignored (empty line, no pulse); r/w/g/q -> latch cmd_code, clear cmd_arg1/2, arg_idx=0, dcnt=0, -> SP; any other char -> ERR.
  - SP: space -> ARG; CR -> DONE if required count is 0, else -> IDLE with cmd_err; other -> ERR.
  - ARG: hex digit -> arg[arg_idx] = {arg[arg_idx][27:0], nibble}, dcnt++; digit when dcnt==MAX_DIGITS -> ERR; digit when arg_idx==required -> ERR; space with dcnt==0 ignored; space with dcnt>0 -> arg_idx++, dcnt=0; CR -> count pending arg (if dcnt>0), then DONE if count==required else IDLE with cmd_err; other char -> ERR.
  - ERR: discard chars until CR -> IDLE with cmd_err.
  - DONE: cmd_valid=1 for one cycle, no pop, -> IDLE.
- cmd_code, cmd_arg1/2 hold their values after cmd_valid until the next command letter is accepted.

## Timing
- Reset: state IDLE; rx_rd, cmd_valid, cmd_err, echo_en, crlf_out = 0; cmd_code=0; cmd_arg1/2=0; echo_char=0.
- Maximum one character per cycle; all state updates on the clk edge of the pop.
- cmd_valid asserts the cycle after the terminating CR is popped; cmd_err likewise (registered).
- cmd_busy high: no pop, state frozen; a command in DONE still pulses cmd_valid.
- rst mid-line: partial arguments dropped, no pulse.

## Configuration
- UART_ECHO_EN defined: every popped char except LF is echoed (echo_en = rx_rd, echo_char = rx_char) except CR, which instead pulses crlf_out; pops also wait on ~tx_fifo_full.
- Undefined: echo_en, crlf_out, echo_char tied 0; tx_fifo_full ignored.

## Test plan
- "r 00001000 0000100f\r" -> cmd_valid one cycle, cmd_code=1, arg1=0x00001000, arg2=0x0000100f.
- "W  1F a\r" (double space, mixed case) -> cmd_code=2, arg1=0x1f, arg2=0xa.
- "g 123456789\r" (9 digits) -> no cmd_valid; cmd_err one cycle after CR; next "q\r" -> cmd_valid, cmd_code=4.
- "x 0\r" and "r 10\r" -> cmd_err each, no cmd_valid; blank "\r\n" -> neither pulse.
- cmd_busy high while "g 0\r" sits in FIFO -> rx_rd=0 throughout; release -> 4 pops, cmd_valid, arg1=0.
- UART_ECHO_EN, tx_fifo_full high 5 cycles during "q\r" -> no pops; then echo_en for 'q', crlf_out for CR, cmd_valid.

Source files
------------

// File: rtl/uart_rec_char.sv
// uart_rec_char: UART monitor command-line decoder.
// Pops ASCII characters from the RX FIFO, parses "<cmd> [hex1] [hex2]<CR>"
// and presents a decoded command (r/w/g/q) with zero-extended arguments.
// Optional local echo to the TX path is enabled by defining UART_ECHO_EN.
`timescale 1ns/1ps
module uart_rec_char #(
  parameter int unsigned MAX_DIGITS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                rx_char,
  input  logic                      rx_fifo_empty,
  output logic                      rx_rd,
  input  logic                      cmd_busy,
  output logic                      cmd_valid,
  output logic                      cmd_err,
  output logic [2:0]                cmd_code,
  output logic [4*MAX_DIGITS-1:0]   cmd_arg1,
  output logic [4*MAX_DIGITS-1:0]   cmd_arg2,
  input  logic                      tx_fifo_full,
  output logic [7:0]                echo_char,
  output logic                      echo_en,
  output logic                      crlf_out
);

  localparam int unsigned ARG_W  = 4 * MAX_DIGITS;
  localparam int unsigned DCNT_W = $clog2(MAX_DIGITS + 1);

  localparam logic [7:0] CH_LF = 8'h0a;
  localparam logic [7:0] CH_CR = 8'h0d;
  localparam logic [7:0] CH_SP = 8'h20;

  localparam logic [2:0] CODE_R = 3'd1;
  localparam logic [2:0] CODE_W = 3'd2;
  localparam logic [2:0] CODE_G = 3'd3;
  localparam logic [2:0] CODE_Q = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SP,
    S_ARG,
    S_ERR,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          code_q, code_d;
  logic [ARG_W-1:0]    arg1_q, arg1_d;
  logic [ARG_W-1:0]    arg2_q, arg2_d;
  logic [1:0]          idx_q, idx_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic                valid_q, err_q, err_d;

  logic                pop_c;
  logic [7:0]          lower_c;
  logic                is_digit_c, is_af_c, is_hex_c;
  logic [3:0]          nibble_c;
  logic [2:0]          letter_code_c;
  logic [1:0]          req_c;
  logic [1:0]          argcnt_c;

  // Character classification: hex nibble value and command-letter code
  always_comb begin
    lower_c       = rx_char | 8'h20;
    is_digit_c    = (rx_char >= 8'h30) && (rx_char <= 8'h39);
    is_af_c       = (lower_c >= 8'h61) && (lower_c <= 8'h66);
    is_hex_c      = is_digit_c || is_af_c;
    nibble_c      = is_digit_c ? 4'(rx_char - 8'h30) : 4'(lower_c - 8'h57);
    letter_code_c = 3'd0;
    case (lower_c)
      8'h72:   letter_code_c = CODE_R;
      8'h77:   letter_code_c = CODE_W;
      8'h67:   letter_code_c = CODE_G;
      8'h71:   letter_code_c = CODE_Q;
      default: letter_code_c = 3'd0;
    endcase
    case (code_q)
      CODE_R, CODE_W: req_c = 2'd2;
      CODE_G:         req_c = 2'd1;
      default:        req_c = 2'd0;
    endcase
    argcnt_c = idx_q + 2'(dcnt_q != '0);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      arg1_q  <= '0;
      arg2_q  <= '0;
      idx_q   <= '0;
      dcnt_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      arg1_q  <= arg1_d;
      arg2_q  <= arg2_d;
      idx_q   <= idx_d;
      dcnt_q  <= dcnt_d;
      valid_q <= (state_d == S_DONE);
      err_q   <= err_d;
    end
  end

  // Next-state and argument accumulation for each popped character (LF ignored)
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    arg1_d  = arg1_q;
    arg2_d  = arg2_q;
    idx_d   = idx_q;
    dcnt_d  = dcnt_q;
    err_d   = 1'b0;
    if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end else if (pop_c && (rx_char != CH_LF)) begin
      case (state_q)
        S_IDLE: begin
          if ((rx_char == CH_SP) || (rx_char == CH_CR)) begin
            state_d = S_IDLE;
          end else if (letter_code_c != 3'd0) begin
            code_d  = letter_code_c;
            arg1_d  = '0;
            arg2_d  = '0;
            idx_d   = '0;
            dcnt_d  = '0;
            state_d = S_SP;
          end else begin
            state_d = S_ERR;
          end
        end
        S_SP: begin
          if (rx_char == CH_SP) begin
            state_d = S_ARG;
          end else if (rx_char == CH_CR) begin
            state_d = (req_c == 2'd0) ? S_DONE : S_IDLE;
            err_d   = (req_c != 2'd0);
          end else begin
            state_d = S_ERR;
          end
        end
        S_ARG: begin
          if (is_hex_c) begin
            if ((dcnt_q == DCNT_W'(MAX_DIGITS)) || (idx_q == req_c)) begin
              state_d = S_ERR;
            end else begin
              if (idx_q == 2'd0) arg1_d = {arg1_q[ARG_W-5:0], nibble_c};
              else               arg2_d = {arg2_q[ARG_W-5:0], nibble_c};
              dcnt_d = dcnt_q + DCNT_W'(1);
            end
          end else if (rx_char == CH_SP) begin
            if (dcnt_q != '0) begin
              idx_d  = idx_q + 2'd1;
              dcnt_d = '0;
            end
          end else if (rx_char == CH_CR) begin
            state_d = (argcnt_c == req_c) ? S_DONE : S_IDLE;
            err_d   = (argcnt_c != req_c);
          end else begin
            state_d = S_ERR;
          end
        end
        S_ERR: begin
          if (rx_char == CH_CR) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Pop strobe and echo outputs (combinational: they qualify the current FIFO head)
  always_comb begin
    pop_c     = ~rst & ~rx_fifo_empty & ~cmd_busy & (state_q != S_DONE);
    echo_en   = 1'b0;
    crlf_out  = 1'b0;
    echo_char = 8'h00;
`ifdef UART_ECHO_EN
    pop_c     = pop_c & ~tx_fifo_full;
    echo_en   = pop_c && (rx_char != CH_LF) && (rx_char != CH_CR);
    crlf_out  = pop_c && (rx_char == CH_CR);
    echo_char = echo_en ? rx_char : 8'h00;
`endif
    rx_rd     = pop_c;
  end

`ifndef UART_ECHO_EN
  logic unused_tx_fifo_full;
  assign unused_tx_fifo_full = tx_fifo_full;
`endif

  assign cmd_valid = valid_q;
  assign cmd_err   = err_q;
  assign cmd_code  = code_q;
  assign cmd_arg1  = arg1_q;
  assign cmd_arg2  = arg2_q;

endmodule

// File: tb/tb_uart_rec_char.sv
// Bench for uart_rec_char: directed lines plus random command lines checked
// against a token-level reference parser. '|' in test strings stands for CR,
// '~' for LF.
`timescale 1ns/1ps
module tb_uart_rec_char;

  typedef byte unsigned bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_char = 8'h00;
  logic        rx_fifo_empty = 1'b1;
  logic        rx_rd;
  logic        cmd_busy = 1'b0;
  logic        cmd_valid, cmd_err;
  logic [2:0]  cmd_code;
  logic [31:0] cmd_arg1, cmd_arg2;
  logic        tx_fifo_full = 1'b0;
  logic [7:0]  echo_char;
  logic        echo_en, crlf_out;

  int          total = 0;
  int          bad = 0;
  bq_t         fifo;
  int          pops = 0;

  uart_rec_char #(.MAX_DIGITS(8)) dut (
    .clk(clk), .rst(rst), .rx_char(rx_char), .rx_fifo_empty(rx_fifo_empty),
    .rx_rd(rx_rd), .cmd_busy(cmd_busy), .cmd_valid(cmd_valid), .cmd_err(cmd_err),
    .cmd_code(cmd_code), .cmd_arg1(cmd_arg1), .cmd_arg2(cmd_arg2),
    .tx_fifo_full(tx_fifo_full), .echo_char(echo_char), .echo_en(echo_en),
    .crlf_out(crlf_out)
  );

  always #5 clk = ~clk;

  // Show-ahead RX FIFO model: pop on rx_rd, present the new head just after the edge
  always @(posedge clk) begin
    if (rx_rd === 1'b1 && fifo.size() != 0) begin
      void'(fifo.pop_front());
      pops++;
    end
    #1;
    rx_fifo_empty = (fifo.size() == 0);
    rx_char       = (fifo.size() != 0) ? fifo[0] : 8'h00;
  end

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "|")      q.push_back(8'h0d);
      else if (s[i] == "~") q.push_back(8'h0a);
      else                  q.push_back(s[i]);
    end
    return q;
  endfunction

  function automatic int hexval(input byte unsigned c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return -1;
  endfunction

  // Reference: tokenise one line and decide valid / error / nothing
  function automatic void model(input bq_t ln, output int ev, output int ee,
                                output logic [2:0] code, output logic [31:0] a1,
                                output logic [31:0] a2);
    bq_t t;
    int i, req, ntok, tl, d;
    bit badl;
    byte unsigned c;
    logic [31:0] vals [3];
    ev = 0; ee = 0; code = 3'd0; a1 = 32'd0; a2 = 32'd0;
    foreach (ln[k]) if (ln[k] != 8'h0a && ln[k] != 8'h0d) t.push_back(ln[k]);
    i = 0;
    while (i < t.size() && t[i] == 8'h20) i++;
    if (i == t.size()) return;
    c = t[i];
    if (c >= "A" && c <= "Z") c = c + 8'd32;
    case (c)
      "r": code = 3'd1;
      "w": code = 3'd2;
      "g": code = 3'd3;
      "q": code = 3'd4;
      default: begin ee = 1; return; end
    endcase
    req = (code == 3'd3) ? 1 : (code == 3'd4) ? 0 : 2;
    i++;
    if (i == t.size()) begin
      if (req == 0) ev = 1; else ee = 1;
      return;
    end
    if (t[i] != 8'h20) begin ee = 1; return; end
    ntok = 0; tl = 0; badl = 0;
    for (int k = 0; k < 3; k++) vals[k] = 32'd0;
    for (; i < t.size(); i++) begin
      if (t[i] == 8'h20) begin
        if (tl > 0) begin ntok++; tl = 0; end
      end else begin
        d = hexval(t[i]);
        if (d < 0) badl = 1;
        else begin
          if (ntok < 3) vals[ntok] = vals[ntok] * 32'd16 + 32'(d);
          tl++;
          if (tl > 8) badl = 1;
        end
      end
    end
    if (tl > 0) ntok++;
    if (badl || ntok != req) ee = 1;
    else begin ev = 1; a1 = vals[0]; a2 = vals[1]; end
  endfunction

  // Run until the FIFO drains, counting pulses and checking echo every cycle
  task automatic run_pending(input string name, input int ev, input int ee,
                             input logic [2:0] ec, input logic [31:0] ea1,
                             input logic [31:0] ea2);
    int nv, ne, idle, cyc, budget;
    logic [2:0] gc;
    logic [31:0] g1, g2;
    logic xe, xc;
    nv = 0; ne = 0; idle = 0; cyc = 0; gc = 3'd0; g1 = 32'd0; g2 = 32'd0;
    budget = 3 * fifo.size() + 40;
    while (cyc < budget && idle < 4) begin
      @(negedge clk);
      cyc++;
`ifdef UART_ECHO_EN
      xe = rx_rd && rx_char != 8'h0a && rx_char != 8'h0d;
      xc = rx_rd && rx_char == 8'h0d;
      total++;
      if (echo_en !== xe || crlf_out !== xc || (xe && echo_char !== rx_char)) begin
        bad++;
        $display("FAIL %s echo: got en=%b crlf=%b ch=%h want en=%b crlf=%b ch=%h",
                 name, echo_en, crlf_out, echo_char, xe, xc, rx_char);
      end
`else
      xe = 1'b0; xc = 1'b0;
      total++;
      if (echo_en !== xe || crlf_out !== xc || echo_char !== 8'h00) begin
        bad++;
        $display("FAIL %s echo_off: got en=%b crlf=%b ch=%h want 0 0 00",
                 name, echo_en, crlf_out, echo_char);
      end
`endif
      if (cmd_valid === 1'b1) begin nv++; gc = cmd_code; g1 = cmd_arg1; g2 = cmd_arg2; end
      if (cmd_err === 1'b1) ne++;
      if (fifo.size() == 0) idle++; else idle = 0;
    end
    total++;
    if (cyc >= budget) begin
      bad++;
      $display("FAIL %s timeout: %0d cycles, fifo left %0d, want drained", name, cyc, fifo.size());
    end
    total++;
    if (nv !== ev || ne !== ee) begin
      bad++;
      $display("FAIL %s pulses: got valid=%0d err=%0d want valid=%0d err=%0d", name, nv, ne, ev, ee);
    end
    if (ev == 1) begin
      total++;
      if (gc !== ec || g1 !== ea1 || g2 !== ea2) begin
        bad++;
        $display("FAIL %s cmd: got code=%0d a1=%h a2=%h want code=%0d a1=%h a2=%h",
                 name, gc, g1, g2, ec, ea1, ea2);
      end
    end
  endtask

  task automatic run_exp(input string s, input int ev, input int ee, input logic [2:0] ec,
                         input logic [31:0] ea1, input logic [31:0] ea2);
    bq_t q;
    q = str2q(s);
    foreach (q[k]) fifo.push_back(q[k]);
    run_pending(s, ev, ee, ec, ea1, ea2);
  endtask

  task automatic run_model(input bq_t q, input string name);
    int ev, ee;
    logic [2:0] ec;
    logic [31:0] a1, a2;
    model(q, ev, ee, ec, a1, a2);
    foreach (q[k]) fifo.push_back(q[k]);
    run_pending(name, ev, ee, ec, a1, a2);
  endtask

  task automatic test_reset();
    bq_t q;
    q = str2q("q|");
    foreach (q[k]) fifo.push_back(q[k]);
    repeat (3) @(negedge clk);
    total++;
    if (rx_rd !== 1'b0 || cmd_valid !== 1'b0 || cmd_err !== 1'b0 || cmd_code !== 3'd0 ||
        cmd_arg1 !== 32'd0 || cmd_arg2 !== 32'd0 || echo_en !== 1'b0 ||
        crlf_out !== 1'b0 || echo_char !== 8'h00) begin
      bad++;
      $display("FAIL reset_state: rd=%b v=%b e=%b code=%0d a1=%h a2=%h een=%b crlf=%b ech=%h want all 0",
               rx_rd, cmd_valid, cmd_err, cmd_code, cmd_arg1, cmd_arg2, echo_en, crlf_out, echo_char);
    end
    rst = 1'b0;
    run_pending("after_reset_q", 1, 0, 3'd4, 32'd0, 32'd0);
  endtask

  task automatic test_directed();
    run_exp("r 00001000 0000100f|", 1, 0, 3'd1, 32'h0000_1000, 32'h0000_100f);
    run_exp("W  1F a|",             1, 0, 3'd2, 32'h1f, 32'ha);
    run_exp("g 123456789|",         0, 1, 3'd0, 32'd0, 32'd0);
    run_exp("q|",                   1, 0, 3'd4, 32'd0, 32'd0);
    run_exp("x 0|",                 0, 1, 3'd0, 32'd0, 32'd0);
    run_exp("r 10|",                0, 1, 3'd0, 32'd0, 32'd0);
    run_exp("|~",                   0, 0, 3'd0, 32'd0, 32'd0);
    run_exp("G fFfFffFf|",          1, 0, 3'd3, 32'hffff_ffff, 32'd0);
    run_exp("q 5|",                 0, 1, 3'd0, 32'd0, 32'd0);
    run_exp("w 1 2 3|",             0, 1, 3'd0, 32'd0, 32'd0);
    run_exp("r1 2|",                0, 1, 3'd0, 32'd0, 32'd0);
    run_exp("g|",                   0, 1, 3'd0, 32'd0, 32'd0);
    run_exp(" w~ 7 8 |",            1, 0, 3'd2, 32'h7, 32'h8);
  endtask

  task automatic test_hold();
    run_exp("r 5 6|", 1, 0, 3'd1, 32'h5, 32'h6);
    run_exp("z|",     0, 1, 3'd0, 32'd0, 32'd0);
    total++;
    if (cmd_code !== 3'd1 || cmd_arg1 !== 32'h5 || cmd_arg2 !== 32'h6) begin
      bad++;
      $display("FAIL hold: got code=%0d a1=%h a2=%h want 1 5 6", cmd_code, cmd_arg1, cmd_arg2);
    end
  endtask

  task automatic test_busy();
    bq_t q;
    int p0;
    bit saw;
    saw = 0;
    @(negedge clk);
    cmd_busy = 1'b1;
    p0 = pops;
    q = str2q("g 0|");
    foreach (q[k]) fifo.push_back(q[k]);
    repeat (8) begin
      @(negedge clk);
      if (rx_rd !== 1'b0) saw = 1;
    end
    total++;
    if (saw || pops != p0) begin
      bad++;
      $display("FAIL busy_stall: got rd_seen=%0d pops=%0d want 0 0", saw, pops - p0);
    end
    cmd_busy = 1'b0;
    run_pending("busy_release", 1, 0, 3'd3, 32'd0, 32'd0);
    total++;
    if (pops - p0 != 4) begin
      bad++;
      $display("FAIL busy_pops: got %0d want 4", pops - p0);
    end
  endtask

  task automatic test_tx_full();
    bq_t q;
    int p0;
    @(negedge clk);
    tx_fifo_full = 1'b1;
    p0 = pops;
`ifdef UART_ECHO_EN
    q = str2q("q|");
    foreach (q[k]) fifo.push_back(q[k]);
    repeat (5) @(negedge clk);
    total++;
    if (pops != p0) begin
      bad++;
      $display("FAIL txfull_stall: got pops=%0d want 0", pops - p0);
    end
    tx_fifo_full = 1'b0;
    run_pending("txfull_release", 1, 0, 3'd4, 32'd0, 32'd0);
`else
    q = str2q("q|");
    foreach (q[k]) fifo.push_back(q[k]);
    run_pending("txfull_ignored", 1, 0, 3'd4, 32'd0, 32'd0);
    tx_fifo_full = 1'b0;
`endif
    total++;
    if (pops - p0 != 2) begin
      bad++;
      $display("FAIL txfull_pops: got %0d want 2", pops - p0);
    end
  endtask

  task automatic test_reset_midline();
    bq_t q;
    int n;
    q = str2q("w 12");
    foreach (q[k]) fifo.push_back(q[k]);
    n = 0;
    while (fifo.size() != 0 && n < 30) begin @(negedge clk); n++; end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (cmd_code !== 3'd0 || cmd_arg1 !== 32'd0 || cmd_valid !== 1'b0 || cmd_err !== 1'b0) begin
      bad++;
      $display("FAIL midline_reset: got code=%0d a1=%h v=%b e=%b want 0 0 0 0",
               cmd_code, cmd_arg1, cmd_valid, cmd_err);
    end
    run_exp(" 34|", 0, 1, 3'd0, 32'd0, 32'd0);
  endtask

  function automatic bq_t gen_line();
    bq_t q;
    string letters;
    byte unsigned c;
    int req, nt, len, d;
    letters = "rwgqRWGQ";
    if ($urandom_range(0, 4) == 0) q.push_back(8'h20);
    if ($urandom_range(0, 9) == 0) c = "x";
    else c = letters[$urandom_range(0, 7)];
    q.push_back(c);
    req = (c == "g" || c == "G") ? 1 : (c == "q" || c == "Q") ? 0 : 2;
    nt = ($urandom_range(0, 9) < 7) ? req : int'($urandom_range(0, 3));
    if (nt == 0 && $urandom_range(0, 1) == 1) begin
      q.push_back(8'h0d);
      return q;
    end
    q.push_back(8'h20);
    for (int t = 0; t < nt; t++) begin
      if (t > 0 || $urandom_range(0, 3) == 0) q.push_back(8'h20);
      if ($urandom_range(0, 5) == 0) q.push_back(8'h20);
      len = ($urandom_range(0, 9) == 0) ? 9 : int'($urandom_range(1, 8));
      for (int k = 0; k < len; k++) begin
        d = int'($urandom_range(0, 15));
        if ($urandom_range(0, 49) == 0)      c = "k";
        else if (d < 10)                     c = 8'(48 + d);
        else if ($urandom_range(0, 1) == 1)  c = 8'(87 + d);
        else                                 c = 8'(55 + d);
        q.push_back(c);
        if ($urandom_range(0, 39) == 0) q.push_back(8'h0a);
      end
    end
    if ($urandom_range(0, 3) == 0) q.push_back(8'h20);
    q.push_back(8'h0d);
    if ($urandom_range(0, 2) == 0) q.push_back(8'h0a);
    return q;
  endfunction

  task automatic test_random();
    bq_t q;
    for (int n = 0; n < 60; n++) begin
      q = gen_line();
      run_model(q, $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_busy();
    test_tx_full();
    test_reset_midline();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
